renode_apb3_completer_bridge: RTL

- APB3 completer (responder) side of the APB3 link: accepts APB3 transfers from a requester and forwards them to a single-outstanding backend request/response port.
- The backend is typically a Renode-connected model or a register file.
- Adds address/alignment decode errors, per-transaction timeout and tag matching, so late or stale backend responses can never complete the wrong transfer.

---
 rtl/renode_apb3_completer_bridge_pkg.sv | 28 ++
 rtl/renode_apb3_completer_bridge_if.sv | 45 ++++
 rtl/renode_apb3_completer_bridge_timeout_counter.sv | 38 +++
 rtl/renode_apb3_completer_bridge.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/renode_apb3_completer_bridge_pkg.sv
// Shared types, response codes and decode helpers for the APB3 completer bridge.
package renode_apb3_completer_bridge_pkg;

    typedef enum logic [1:0] {
        RQ_IDLE,
        RQ_SETUP,
        RQ_ACCESS
    } requester_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } bridge_state_e;

    localparam logic ApbOkay   = 1'b0;
    localparam logic ApbSlvErr = 1'b1;

    // True when addr is a whole multiple of the bus width in bytes.
    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned data_width);
        logic [63:0] mask;
        mask = 64'((data_width / 8) - 1);
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/renode_apb3_completer_bridge_if.sv
// APB3 completer link plus single-outstanding backend request/response port.
interface renode_apb3_completer_bridge_if #(
    parameter int unsigned AddressWidth = 20,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned TagWidth     = 4
);
    logic [AddressWidth-1:0] paddr;
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic                    pready;
    logic [DataWidth-1:0]    prdata;
    logic                    pslverr;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [AddressWidth-1:0] req_addr;
    logic [DataWidth-1:0]    req_wdata;
    logic [TagWidth-1:0]     req_tag;
    logic                    rsp_valid;
    logic [TagWidth-1:0]     rsp_tag;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_error;

    logic                    protocol_error;
    logic                    timeout_event;

    modport slave (
        input  paddr, pselx, penable, pwrite, pwdata,
        input  req_ready, rsp_valid, rsp_tag, rsp_rdata, rsp_error,
        output pready, prdata, pslverr,
        output req_valid, req_write, req_addr, req_wdata, req_tag,
        output protocol_error, timeout_event
    );

    modport master (
        output paddr, pselx, penable, pwrite, pwdata,
        output req_ready, rsp_valid, rsp_tag, rsp_rdata, rsp_error,
        input  pready, prdata, pslverr,
        input  req_valid, req_write, req_addr, req_wdata, req_tag,
        input  protocol_error, timeout_event
    );
endinterface

// File: rtl/renode_apb3_completer_bridge_timeout_counter.sv
// Per-transaction cycle counter; expired_o is high once TimeoutCycles-1 is reached.
module renode_apb3_completer_bridge_timeout_counter #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] count_q, count_d;
    logic                expired_q;

    always_comb begin
        count_d = count_q;
        if (start_i || clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CntLast)) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == CntLast);
        end
    end

    assign expired_o = expired_q;
endmodule

// File: rtl/renode_apb3_completer_bridge.sv
// APB3 completer that forwards transfers to a tagged single-outstanding backend,
// with decode errors, per-transfer timeout and stale-response rejection.
module renode_apb3_completer_bridge
    import renode_apb3_completer_bridge_pkg::*;
#(
    parameter int unsigned AddressWidth  = 20,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrLimit     = 32'h0001_0000,
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned TagWidth      = 4
) (
    input logic clk,
    input logic rst,
    renode_apb3_completer_bridge_if.slave bus
);
    bridge_state_e           state_q, state_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DataWidth-1:0]    prdata_q, prdata_d;
    logic                    req_valid_q, req_valid_d;
    logic                    req_write_q, req_write_d;
    logic [AddressWidth-1:0] req_addr_q, req_addr_d;
    logic [DataWidth-1:0]    req_wdata_q, req_wdata_d;
    logic [TagWidth-1:0]     req_tag_q, req_tag_d;
    logic                    protocol_error_q, protocol_error_d;
    logic                    timeout_event_q, timeout_event_d;

    logic access_c, setup_c, decode_err_c, rsp_match_c;
    logic cnt_start_c, cnt_clear_c, cnt_enable_c, expired;

    assign access_c     = bus.pselx & bus.penable;
    assign setup_c      = bus.pselx & ~bus.penable;
    assign decode_err_c = (32'(bus.paddr) >= AddrLimit) || !is_aligned(64'(bus.paddr), DataWidth);
    assign rsp_match_c  = bus.rsp_valid && (bus.rsp_tag == req_tag_q);

    always_comb begin
        state_d          = state_q;
        pready_d         = 1'b0;
        pslverr_d        = ApbOkay;
        prdata_d         = prdata_q;
        req_valid_d      = 1'b0;
        req_write_d      = req_write_q;
        req_addr_d       = req_addr_q;
        req_wdata_d      = req_wdata_q;
        req_tag_d        = req_tag_q;
        protocol_error_d = 1'b0;
        timeout_event_d  = 1'b0;
        cnt_start_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (setup_c) begin
                    req_addr_d  = bus.paddr;
                    req_write_d = bus.pwrite;
                    req_wdata_d = bus.pwdata;
                    if (decode_err_c) begin
                        state_d   = S_ERR;
                        pready_d  = 1'b1;
                        pslverr_d = ApbSlvErr;
                        prdata_d  = '0;
                    end else begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_tag_d   = req_tag_q + TagWidth'(1);
                        cnt_start_c = 1'b1;
                    end
                end else if (access_c) begin
                    protocol_error_d = 1'b1;
                end
            end
            S_REQ, S_WAIT: begin
                // Requester abandoned the access phase: abort without completing.
                if (!access_c) begin
                    state_d          = S_IDLE;
                    protocol_error_d = 1'b1;
                end else if ((state_q == S_WAIT) && rsp_match_c) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = bus.rsp_error;
                    prdata_d  = req_write_q ? '0 : bus.rsp_rdata;
                end else if (expired) begin
                    state_d         = S_RESP;
                    pready_d        = 1'b1;
                    pslverr_d       = ApbSlvErr;
                    prdata_d        = '0;
                    timeout_event_d = 1'b1;
                end else if (state_q == S_REQ) begin
                    if (bus.req_ready) begin
                        state_d = S_WAIT;
                    end else begin
                        req_valid_d = 1'b1;
                    end
                end
            end
            S_RESP, S_ERR: begin
                state_d          = S_IDLE;
                protocol_error_d = ~access_c;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_enable_c = (state_q == S_REQ) || (state_q == S_WAIT);
    assign cnt_clear_c  = !((state_d == S_REQ) || (state_d == S_WAIT));

    renode_apb3_completer_bridge_timeout_counter #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .start_i  (cnt_start_c),
        .clear_i  (cnt_clear_c),
        .enable_i (cnt_enable_c),
        .expired_o(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            pready_q         <= 1'b0;
            pslverr_q        <= 1'b0;
            prdata_q         <= '0;
            req_valid_q      <= 1'b0;
            req_write_q      <= 1'b0;
            req_addr_q       <= '0;
            req_wdata_q      <= '0;
            req_tag_q        <= '0;
            protocol_error_q <= 1'b0;
            timeout_event_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            pready_q         <= pready_d;
            pslverr_q        <= pslverr_d;
            prdata_q         <= prdata_d;
            req_valid_q      <= req_valid_d;
            req_write_q      <= req_write_d;
            req_addr_q       <= req_addr_d;
            req_wdata_q      <= req_wdata_d;
            req_tag_q        <= req_tag_d;
            protocol_error_q <= protocol_error_d;
            timeout_event_q  <= timeout_event_d;
        end
    end

    assign bus.pready         = pready_q;
    assign bus.pslverr        = pslverr_q;
    assign bus.prdata         = prdata_q;
    assign bus.req_valid      = req_valid_q;
    assign bus.req_write      = req_write_q;
    assign bus.req_addr       = req_addr_q;
    assign bus.req_wdata      = req_wdata_q;
    assign bus.req_tag        = req_tag_q;
    assign bus.protocol_error = protocol_error_q;
    assign bus.timeout_event  = timeout_event_q;
endmodule
